// File: rtl/counter_mod_updown_pkg.sv
// Shared definitions for the modulo up/down counter family: parameter legality
// and the one-bit headroom used by the next-state compare.
package mantle_counter_pkg;

  // Headroom so O >= MAX stays a plain unsigned compare even when MAX is full scale.
  localparam int EXT_BITS = 1;

  function automatic longint unsigned full_scale(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction

  function automatic bit params_legal(input int width,
                                      input longint unsigned max,
                                      input longint unsigned init);
    return (width >= 1) && (width <= 32) && (max > 0) &&
           (max <= full_scale(width)) && (init <= max);
  endfunction

endpackage

// File: rtl/counter_mod_updown_if.sv
// Control and status bundle of one counter stage. The counter is the slave;
// whoever drives CE/LD/UP/I is the master.
interface counter_mod_updown_if #(
  parameter int WIDTH = 8
);
  logic             CE;
  logic             LD;
  logic             UP;
  logic [WIDTH-1:0] I;
  logic [WIDTH-1:0] O;
  logic             COUT;

  modport master (output CE, LD, UP, I, input O, COUT);
  modport slave  (input CE, LD, UP, I, output O, COUT);
endinterface

// File: rtl/counter_mod_updown_next.sv
// Combinational next-value and wrap indicator for the modulo up/down counter.
// Kept apart from the register so it can be checked on its own.
module counter_mod_next
  import mantle_counter_pkg::*;
#(
  parameter int              WIDTH = 8,
  parameter longint unsigned MAX   = full_scale(WIDTH)
) (
  input  logic [WIDTH-1:0] o,
  input  logic             up,
  input  logic             ce,
  input  logic             ld,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] nxt,
  output logic             cout
);

  localparam int             EXT     = WIDTH + EXT_BITS;
  localparam logic [63:0]    MAX64   = MAX;
  localparam logic [EXT-1:0] MAX_EXT = MAX64[EXT-1:0];

  logic [EXT-1:0] o_ext;
  logic [EXT-1:0] inc_ext;
  logic [EXT-1:0] dec_ext;
  logic [EXT-1:0] nxt_ext;
  logic           at_top;
  logic           at_zero;

  assign o_ext   = {{EXT_BITS{1'b0}}, o};
  assign inc_ext = o_ext + EXT'(1);
  assign dec_ext = o_ext - EXT'(1);
  // Loaded values above MAX also count as "at top" so they wrap to 0 going up.
  assign at_top  = (o_ext >= MAX_EXT);
  assign at_zero = (o == '0);

  always_comb begin
    nxt_ext = o_ext;
    if (ld) begin
      nxt_ext = {{EXT_BITS{1'b0}}, i};
    end else if (ce) begin
      if (up) nxt_ext = at_top  ? '0      : inc_ext;
      else    nxt_ext = at_zero ? MAX_EXT : dec_ext;
    end
  end

  assign nxt  = nxt_ext[WIDTH-1:0];
  assign cout = ce & ~ld & ((up & at_top) | (~up & at_zero));

  // Wrap selection never leaves anything in the headroom bit.
  always_comb assert (nxt_ext[EXT-1:WIDTH] == '0);

endmodule

// File: rtl/counter_mod_updown.sv
// Parametrised modulo up/down counter with load, enable and async reset.
// Holds only the register; next-state logic lives in counter_mod_next.
module counter_mod_updown
  import mantle_counter_pkg::*;
#(
  parameter int              WIDTH = 8,
  parameter longint unsigned MAX   = full_scale(WIDTH),
  parameter longint unsigned INIT  = 0
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  counter_mod_updown_if.slave  bus
);

  if (!params_legal(WIDTH, MAX, INIT)) begin : g_param_check
    $error("counter_mod_updown: illegal WIDTH/MAX/INIT combination");
  end

  localparam logic [63:0]      INIT64 = INIT;
  localparam logic [WIDTH-1:0] INIT_W = INIT64[WIDTH-1:0];

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_nxt;

  counter_mod_next #(
    .WIDTH (WIDTH),
    .MAX   (MAX)
  ) u_next (
    .o    (count),
    .up   (bus.UP),
    .ce   (bus.CE),
    .ld   (bus.LD),
    .i    (bus.I),
    .nxt  (count_nxt),
    .cout (bus.COUT)
  );

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) count <= INIT_W;
    else              count <= count_nxt;
  end

  assign bus.O = count;

endmodule

// File: tb/tb_counter_mod_updown.sv
// Scoreboard bench for counter_mod_updown: reset, modulo wrap both ways,
// load priority, hold, full-scale legacy wrap and a two-stage cascade.
module tb_counter_mod_updown;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // lanes: 0 = W8 INIT5, 1 = W4 MAX9, 2 = W8 full scale, 3 = cascade low stage
  logic        ce[4];
  logic        ld[4];
  logic        up[4];
  logic [7:0]  ival[4];
  logic [7:0]  o_mon[4];
  logic        cout_mon[4];
  int unsigned mdl[4];
  int unsigned maxv[4];
  int unsigned pulses[4];

  int n_chk = 0;
  int n_err = 0;
  int unsigned exp_q[$];
  string       tag_q[$];

  counter_mod_updown_if #(.WIDTH(8)) r_if ();
  counter_mod_updown_if #(.WIDTH(4)) m_if ();
  counter_mod_updown_if #(.WIDTH(8)) l_if ();
  counter_mod_updown_if #(.WIDTH(4)) c0_if ();
  counter_mod_updown_if #(.WIDTH(4)) c1_if ();

  counter_mod_updown #(.WIDTH(8), .INIT(5)) u_rst (.CLK(clk), .ASYNCRESETN(rst_n), .bus(r_if.slave));
  counter_mod_updown #(.WIDTH(4), .MAX(9))  u_mod (.CLK(clk), .ASYNCRESETN(rst_n), .bus(m_if.slave));
  counter_mod_updown #(.WIDTH(8))           u_leg (.CLK(clk), .ASYNCRESETN(rst_n), .bus(l_if.slave));
  counter_mod_updown #(.WIDTH(4), .MAX(15)) u_c0  (.CLK(clk), .ASYNCRESETN(rst_n), .bus(c0_if.slave));
  counter_mod_updown #(.WIDTH(4), .MAX(15)) u_c1  (.CLK(clk), .ASYNCRESETN(rst_n), .bus(c1_if.slave));

  assign r_if.CE = ce[0];  assign r_if.LD = ld[0];  assign r_if.UP = up[0];  assign r_if.I = ival[0];
  assign m_if.CE = ce[1];  assign m_if.LD = ld[1];  assign m_if.UP = up[1];  assign m_if.I = ival[1][3:0];
  assign l_if.CE = ce[2];  assign l_if.LD = ld[2];  assign l_if.UP = up[2];  assign l_if.I = ival[2];
  assign c0_if.CE = ce[3]; assign c0_if.LD = ld[3]; assign c0_if.UP = up[3]; assign c0_if.I = ival[3][3:0];
  assign c1_if.CE = c0_if.COUT;
  assign c1_if.LD = 1'b0;
  assign c1_if.UP = 1'b1;
  assign c1_if.I  = 4'h0;

  assign o_mon[0] = r_if.O;          assign cout_mon[0] = r_if.COUT;
  assign o_mon[1] = {4'h0, m_if.O};  assign cout_mon[1] = m_if.COUT;
  assign o_mon[2] = l_if.O;          assign cout_mon[2] = l_if.COUT;
  assign o_mon[3] = {4'h0, c0_if.O}; assign cout_mon[3] = c0_if.COUT;

  task automatic check_val(input string tag, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int unsigned exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_pop_check(input int unsigned act);
    string       t;
    int unsigned e;
    if (exp_q.size() == 0) begin
      check_val("sb_underflow", 32'(exp_q.size()), 1);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    check_val(t, act, e);
  endtask

  function automatic int unsigned model_next(input int unsigned o, input bit c, input bit l,
                                             input bit u, input int unsigned iv, input int unsigned mx);
    if (l)  return iv;
    if (!c) return o;
    if (u)  return (o >= mx) ? 0 : o + 1;
    return (o == 0) ? mx : o - 1;
  endfunction

  function automatic bit model_cout(input int unsigned o, input bit c, input bit l,
                                    input bit u, input int unsigned mx);
    return c && !l && ((u && o >= mx) || (!u && o == 0));
  endfunction

  // One clock of stimulus on a lane: COUT is checked before the edge, O after it.
  task automatic step(input int lane, input bit c, input bit l, input bit u,
                      input int unsigned iv, input string tag);
    int unsigned nxt;
    @(negedge clk);
    ce[lane]   = c;
    ld[lane]   = l;
    up[lane]   = u;
    ival[lane] = 8'(iv);
    sb_push({tag, "_cout"}, 32'(model_cout(mdl[lane], c, l, u, maxv[lane])));
    nxt = model_next(mdl[lane], c, l, u, iv, maxv[lane]);
    sb_push({tag, "_o"}, nxt);
    mdl[lane] = nxt;
    #1;
    sb_pop_check(32'(cout_mon[lane]));
    if (cout_mon[lane]) pulses[lane]++;
    @(posedge clk);
    #1;
    sb_pop_check(32'(o_mon[lane]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      ce[k] = 1'b0; ld[k] = 1'b0; up[k] = 1'b1; ival[k] = 8'h00; pulses[k] = 0;
    end
    mdl  = '{5, 0, 0, 0};
    maxv = '{255, 9, 255, 15};

    // reset is asynchronous: value appears without a clock edge
    #1 rst_n = 1'b0;
    #1;
    sb_push("rst_async_o", 5);    sb_pop_check(32'(o_mon[0]));
    sb_push("rst_async_cout", 0); sb_pop_check(32'(cout_mon[0]));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) step(0, 1, 0, 1, 0, "rst_up");
    sb_push("rst_up3", 8); sb_pop_check(32'(o_mon[0]));

    // mid-cycle reset with CE still high, then LD held during reset
    #3 rst_n = 1'b0;
    #1;
    sb_push("rst_mid_o", 5);    sb_pop_check(32'(o_mon[0]));
    sb_push("rst_mid_cout", 0); sb_pop_check(32'(cout_mon[0]));
    mdl[0]  = 5;
    ld[0]   = 1'b1;
    ival[0] = 8'd77;
    @(posedge clk);
    #1;
    sb_push("rst_beats_ld", 5); sb_pop_check(32'(o_mon[0]));
    @(negedge clk);
    ce[0] = 1'b0;
    ld[0] = 1'b0;
    rst_n = 1'b1;
    repeat (3) step(0, 1, 0, 1, 0, "rel_up");
    sb_push("rel_up3", 8); sb_pop_check(32'(o_mon[0]));
    step(0, 0, 0, 1, 0, "rst_park");

    // modulo 10 up-wrap: exactly one COUT in ten edges
    repeat (10) step(1, 1, 0, 1, 0, "mod_up");
    sb_push("mod_up_pulses", 1); sb_pop_check(pulses[1]);
    sb_push("mod_up_wrap", 0);   sb_pop_check(32'(o_mon[1]));

    // down-wrap 1,0,9,8
    step(1, 0, 1, 0, 1, "mod_ld1");
    repeat (3) step(1, 1, 0, 0, 0, "mod_dn");
    sb_push("mod_dn_end", 8); sb_pop_check(32'(o_mon[1]));

    // load beats CE; out-of-range value wraps up to 0, counts down into range
    step(1, 1, 1, 1, 13, "ld_pri");
    sb_push("ld_pri_val", 13); sb_pop_check(32'(o_mon[1]));
    step(1, 1, 0, 1, 0, "oor_up");
    sb_push("oor_up_val", 0); sb_pop_check(32'(o_mon[1]));
    step(1, 0, 1, 0, 13, "reld");
    repeat (4) step(1, 1, 0, 0, 0, "oor_dn");
    sb_push("oor_dn_end", 9); sb_pop_check(32'(o_mon[1]));

    // direction reversal at zero gives 1 without a wrap
    step(1, 0, 1, 0, 0, "ld0");
    step(1, 1, 0, 1, 0, "rev_up");
    sb_push("rev_val", 1); sb_pop_check(32'(o_mon[1]));

    // hold with direction toggling
    for (int k = 0; k < 4; k++) step(1, 0, 0, k[0], 0, "hold");
    sb_push("hold_val", 1); sb_pop_check(32'(o_mon[1]));

    // full-scale 8-bit counter behaves like the legacy carry-out counter
    repeat (256) step(2, 1, 0, 1, 0, "leg");
    sb_push("leg_pulses", 1); sb_pop_check(pulses[2]);
    sb_push("leg_wrap", 0);   sb_pop_check(32'(o_mon[2]));
    step(2, 0, 0, 1, 0, "leg_park");

    // two 4-bit stages chained COUT -> CE
    repeat (300) step(3, 1, 0, 1, 0, "cas0");
    step(3, 0, 0, 1, 0, "cas_park");
    sb_push("cascade_300", 44); sb_pop_check(32'({c1_if.O, c0_if.O}));

    check_val("sb_drain", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
